// File: rtl/hsc_tdc_top.sv
// Delay-line TDC core: launch-edge select, N-stage kept delay line, capture, synchroniser
// and Hamming-weight readout. A valid flag travels alongside the data and stays aligned with hw.
module hsc_tdc_top #(
  parameter int    N          = 64,
  parameter string DL_TYPE    = "DBUF",
  parameter int    N_SYNC     = 1,
  parameter string POP_METHOD = "SV",
  localparam int   HW_W       = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            val_in,
  input  logic            pg_src,
  input  logic            pg_bypass,
  input  logic            pg_in,
  input  logic            pg_tog,
  output logic [HW_W-1:0] hw,
  output logic            val_out
);

  localparam int LVL = $clog2(N);

  logic            tog_q;
  logic            src_q;
  logic            src;
  logic            dl_in;
  logic [N-1:0]    tap;
  logic [N-1:0]    cap;
  logic [N-1:0]    sync [N_SYNC];
  logic [HW_W-1:0] pop_sum;
  logic [HW_W-1:0] hw_reg;
  logic [N_SYNC+1:0] vld;

  assign src   = pg_src ? tog_q : pg_in;
  assign dl_in = pg_bypass ? src : src_q;

  // Launch path. src_q freezes with en so a paused toggle sequence resumes exactly where it stopped.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q <= 1'b0;
      src_q <= 1'b0;
    end else if (en) begin
      if (pg_tog) tog_q <= ~tog_q;
      src_q <= src;
    end
  end

  // One kept cell per stage; a flattened chain would let synthesis optimise the line away.
  for (genvar i = 0; i < N; i++) begin : g_stage
    logic cell_in;
    (* keep = "true", dont_touch = "true" *) logic cell_out;

    if (i == 0) begin : g_first
      assign cell_in = dl_in;
    end else begin : g_next
      assign cell_in = g_stage[i-1].cell_out;
    end

    if (DL_TYPE == "INV") begin : g_inv
      assign cell_out = ~cell_in;
      // Even (0-based) taps sit behind an odd number of inverters, so flip them back.
      assign tap[i] = (i % 2 == 0) ? ~cell_out : cell_out;
    end else begin : g_buf
      assign cell_out = cell_in;
      assign tap[i]   = cell_out;
    end
  end

  // Capture, synchroniser and valid pipeline all advance together, only while en is high.
  // NOTE: these are pipeline registers, not a RAM, so every stage is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
      for (int k = 0; k < N_SYNC; k++) sync[k] <= '0;
      hw_reg <= '0;
      vld    <= '0;
    end else if (en) begin
      cap     <= tap;
      sync[0] <= cap;
      for (int k = 1; k < N_SYNC; k++) sync[k] <= sync[k-1];
      hw_reg <= pop_sum;
      vld    <= {vld[N_SYNC:0], val_in};
    end
  end

  if (POP_METHOD == "TREE") begin : g_pop_tree
    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
      logic [HW_W-1:0] s [N >> l];
      for (genvar i = 0; i < (N >> l); i++) begin : g_node
        if (l == 0) begin : g_leaf
          assign s[i] = {{(HW_W-1){1'b0}}, sync[N_SYNC-1][i]};
        end else begin : g_add
          assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
        end
      end
    end
    assign pop_sum = g_lvl[LVL].s[0];
  end else begin : g_pop_sv
    // NOTE: the accumulator is assigned before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
      pop_sum = '0;
      for (int i = 0; i < N; i++) pop_sum = pop_sum + {{(HW_W-1){1'b0}}, sync[N_SYNC-1][i]};
    end
  end

  assign hw      = hw_reg;
  assign val_out = vld[N_SYNC+1] & en;

endmodule

// File: tb/tb_hsc_tdc_top.sv
// Directed bench for hsc_tdc_top: one DBUF/SV instance and one INV/TREE instance share stimulus,
// and both are checked against the same hand-computed expectations.
module tb_hsc_tdc_top;

  localparam int N    = 64;
  localparam int HW_W = $clog2(N) + 1;

  logic clk = 1'b0;
  logic rst_n, en, val_in, pg_src, pg_bypass, pg_in, pg_tog;
  logic [HW_W-1:0] hw_sv, hw_tr;
  logic            vo_sv, vo_tr;
  logic [N-1:0]    pat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hsc_tdc_top #(.N(N), .DL_TYPE("DBUF"), .N_SYNC(1), .POP_METHOD("SV")) dut_sv (
    .clk(clk), .rst_n(rst_n), .en(en), .val_in(val_in), .pg_src(pg_src),
    .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog), .hw(hw_sv), .val_out(vo_sv)
  );

  hsc_tdc_top #(.N(N), .DL_TYPE("INV"), .N_SYNC(1), .POP_METHOD("TREE")) dut_tr (
    .clk(clk), .rst_n(rst_n), .en(en), .val_in(val_in), .pg_src(pg_src),
    .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog), .hw(hw_tr), .val_out(vo_tr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Checks hw and val_out of both instances against one expectation.
  task automatic check_both(input string tag, input int exp_hw, input logic exp_vo);
    check({tag, " hw sv"},  32'(hw_sv), 32'(exp_hw));
    check({tag, " hw tr"},  32'(hw_tr), 32'(exp_hw));
    check({tag, " vo sv"},  32'(vo_sv), 32'(exp_vo));
    check({tag, " vo tr"},  32'(vo_tr), 32'(exp_vo));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int tog_exp [8] = '{0, 0, 0, 0, 64, 0, 64, 0};
    int res_exp [3] = '{0, 64, 0};
    logic [N-1:0] pats [6];
    int           pop_exp [6] = '{0, 64, 32, 1, 32, 1};

    pats[0] = '0;
    pats[1] = '1;
    pats[2] = 64'h5555_5555_5555_5555;
    pats[3] = 64'h0000_0100_0000_0000;
    pats[4] = 64'h00FF_00FF_00FF_00FF;
    pats[5] = 64'h8000_0000_0000_0000;

    // Reset with random inputs
    rst_n     = 1'b0;
    en        = 1'($urandom);
    val_in    = 1'($urandom);
    pg_src    = 1'($urandom);
    pg_bypass = 1'($urandom);
    pg_in     = 1'($urandom);
    pg_tog    = 1'($urandom);
    pat       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_both("reset", 0, 1'b0);

    // Release with pg_in low: hw must stay 0
    en = 1'b1; val_in = 1'b0; pg_src = 1'b0; pg_bypass = 1'b1; pg_in = 1'b0; pg_tog = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check_both("post-release low", 0, 1'b0);

    // Static high via bypass: capture edge 1, hw at edge 3
    pg_in = 1'b1; val_in = 1'b1;
    step(2);
    check_both("static high edge2", 0, 1'b0);
    step(1);
    check_both("static high edge3", 64, 1'b1);

    // Static low with one-cycle valid pulse
    pg_in = 1'b0; val_in = 1'b0;
    step(3);
    check_both("static low settle", 0, 1'b0);
    val_in = 1'b1;
    step(1);
    val_in = 1'b0;
    step(1);
    check_both("pulse c+1", 0, 1'b0);
    step(1);
    check_both("pulse c+2", 0, 1'b1);
    step(1);
    check_both("pulse c+3", 0, 1'b0);

    // Toggle source, registered path, from reset
    rst_n = 1'b0;
    pg_src = 1'b1; pg_tog = 1'b1; pg_bypass = 1'b0; val_in = 1'b1; en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step(1);
      check_both($sformatf("toggle edge%0d", n), tog_exp[n-1], n >= 3);
    end

    // Enable freeze for 3 edges after edge 7
    en = 1'b0;
    #1;
    check_both("freeze entry", 64, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step(1);
      check_both($sformatf("freeze edge%0d", n), 64, 1'b0);
      check("freeze tog_q", 32'(dut_sv.tog_q), 32'd1);
    end
    en = 1'b1;
    #1;
    check_both("freeze exit", 64, 1'b1);
    for (int n = 0; n < 3; n++) begin
      step(1);
      check_both($sformatf("resume edge%0d", n), res_exp[n], 1'b1);
    end

    // Popcount equivalence on forced capture patterns
    for (int p = 0; p < 6; p++) begin
      pat = pats[p];
      force dut_sv.cap = pat;
      force dut_tr.cap = pat;
      step(2);
      check($sformatf("pop sv %0d", p), 32'(hw_sv), 32'(pop_exp[p]));
      check($sformatf("pop tr %0d", p), 32'(hw_tr), 32'(pop_exp[p]));
    end
    release dut_sv.cap;
    release dut_tr.cap;

    // Mid-operation reset flushes data and valid
    pg_src = 1'b0; pg_bypass = 1'b1; pg_in = 1'b1; pg_tog = 1'b0; val_in = 1'b1;
    step(4);
    check_both("pre-reset high", 64, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_both("async reset", 0, 1'b0);
    @(negedge clk);
    val_in = 1'b0; pg_in = 1'b0;
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step(1);
      check_both($sformatf("after flush edge%0d", n), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
